alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that runs MULTU/DIVU on the shared 32-bit ALU (ctrl codes AND 000, OR 001, ADD 010, SUB 110, SLT 111) and produces HI/LO.
- Sits beside the EX stage.
- While idle, it passes EX-stage ALU requests through to the ALU.
- While busy, it owns the ALU and stalls the pipeline through `busy`.

Parameters:
- ITER, 32, iteration count (operand width; only 32 is supported)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `op`  in  2  00 = MULTU, 01 = DIVU; 1x is illegal and start is ignored
- `srcA`  in  32  multiplicand / dividend
- `srcB`  in  32  multiplier / divisor
- `ex_signal`  in  3  EX-stage ALU control (pass-through)
- `ex_a`  in  32  EX-stage operand A (pass-through)
- `ex_b`  in  32  EX-stage operand B (pass-through)
- `alu_signal`  out  3  to shared ALU `Signal`
- `alu_a`  out  32  to ALU `dataA`
- `alu_b`  out  32  to ALU `dataB`
- `alu_result`  in  32  from ALU `dataOut`
- `busy`  out  1  high when state is not IDLE
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid
- `hi`  out  32  product high word / remainder
- `lo`  out  32  product low word / quotient
- `div_zero`  out  1  set on DIVU with srcB == 0; held until the next accepted start

Behaviour:
- Reset (`rst` == 0 at an edge) overrides everything, including mid-operation:
  - state goes to IDLE; `hi`, `lo` = 0; `done`, `div_zero`, `busy` = 0; iteration counter = 0.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
- ALU mux:
  - In IDLE, `alu_signal`/`alu_a`/`alu_b` = `ex_signal`/`ex_a`/`ex_b`.
  - In all other states, the sequencer drives the ALU.
- IDLE, on `start` with a legal `op`:
  - Latch operands, clear `div_zero`, counter = 0.
  - MULTU: P_hi = 0, P_lo = srcB, M = srcA; next state MUL.
  - DIVU with srcB != 0: R = 0, Q = srcA, D = srcB; next state DIV_CMP.
  - DIVU with srcB == 0: `hi` = srcA, `lo` = 0xFFFFFFFF, `div_zero` = 1; next state DONE.
- `start` outside IDLE is ignored; no queueing.
- MUL, one iteration per cycle:
  - Drive ADD; `alu_a` = P_hi; `alu_b` = P_lo[0] ? M : 0.
  - Carry: c = (a31 & b31) | ((a31 | b31) & ~result31).
  - Update {P_hi, P_lo} <= {c, alu_result, P_lo[31:1]}.
  - After the 32nd iteration go to DONE.
- DIV_CMP:
  - Form S = {R[30:0], Q[31]} and ov = R[31].
  - Drive SLT(S, D); the ALU's SLT is the unsigned borrow compare.
  - Register S, ov, lt = alu_result[0]; Q <= Q << 1.
- DIV_SUB:
  - Drive SUB(S, D).
  - If ov | ~lt: R <= alu_result and Q[0] <= 1.
  - Else: R <= S and Q[0] <= 0.
  - Counter increments; after 32 iterations go to DONE, otherwise return to DIV_CMP.
- DONE (one cycle):
  - `done` = 1.
  - `hi`/`lo` were loaded on entry: MUL gives P_hi/P_lo; DIV gives R/Q.
  - Next state IDLE.
- `hi`/`lo` hold their value until the next completion or reset.
- Latency, counting the start cycle as 0:
  - MULTU: `done` in cycle 33.
  - DIVU: `done` in cycle 65.
  - Divide-by-zero: `done` in cycle 1.
  - `busy` is high from cycle 1 through the DONE cycle.
- A back-to-back start is accepted in the cycle after DONE.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` exactly in cycle 33; `busy` high in cycles 1–33.
- DIVU 100 / 7:
  - `lo` = 14, `hi` = 2, `div_zero` = 0; `done` in cycle 65.
- DIVU 0xFFFFFFFF / 0x80000001 (exercises the ov path):
  - `lo` = 1, `hi` = 0x7FFFFFFE.
- DIVU 0x12345678 / 0:
  - `done` in cycle 1; `hi` = 0x12345678, `lo` = 0xFFFFFFFF, `div_zero` = 1.
  - A following MULTU 3 × 5 clears `div_zero` and gives `hi` = 0, `lo` = 15.
- Pass-through and busy behaviour:
  - In IDLE, `ex_signal` = 010, `ex_a` = 5, `ex_b` = 7 appear on the ALU outputs the same cycle.
  - During MUL, the ALU outputs are not the ex_* values.
  - A start pulse mid-operation, and a start with `op` = 11 in IDLE, are both ignored (no state change).
- Reset mid-operation:
  - Drive `rst` = 0 at cycle 10 of a MULTU.
  - Next cycle: state IDLE, `busy` = 0, `hi` = `lo` = 0, no `done` pulse.
  - A new start then completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MULTU/DIVU sequencer that borrows the shared
// 32-bit EX-stage ALU. It passes EX requests through while idle, takes the ALU
// over while busy, and stalls the pipeline through busy.
module alu_muldiv_seq #(
    parameter int ITER = 32  // operand width / iteration count; only 32 supported
) (
    input  logic        clk,
    input  logic        rst,          // synchronous, active low
    input  logic        start,
    input  logic [1:0]  op,           // 00 MULTU, 01 DIVU, 1x ignored
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  ex_signal,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    output logic [2:0]  alu_signal,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t      state, state_n;

    // acc_hi holds P_hi (multiply) or the remainder R (divide); acc_lo holds
    // P_lo or the quotient Q; operand holds the multiplicand M or divisor D.
    logic [31:0] acc_hi, acc_lo, operand;
    logic [31:0] s_reg;       // shifted partial remainder S from DIV_CMP
    logic        ov_reg;      // bit shifted out of R: S is really >= 2^32
    logic        lt_reg;      // S < D from the SLT compare
    logic [4:0]  cnt;

    logic        accept;
    logic        last_iter;
    logic [31:0] div_s;
    logic        mul_carry;
    logic [31:0] mul_hi_n, mul_lo_n;
    logic        div_take;
    logic [31:0] rem_n, quo_n;

    assign accept    = start && !op[1];
    assign last_iter = (cnt == LAST_ITER);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Datapath helpers: next partial product and next remainder/quotient.
    assign div_s     = {acc_hi[30:0], acc_lo[31]};
    assign mul_carry = (alu_a[31] & alu_b[31]) |
                       ((alu_a[31] | alu_b[31]) & ~alu_result[31]);
    assign mul_hi_n  = {mul_carry, alu_result[31:1]};
    assign mul_lo_n  = {alu_result[0], acc_lo[31:1]};
    assign div_take  = ov_reg | ~lt_reg;
    assign rem_n     = div_take ? alu_result : s_reg;
    assign quo_n     = {acc_lo[31:1], div_take};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state logic and ALU ownership mux.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n    = state;
        alu_signal = ex_signal;
        alu_a      = ex_a;
        alu_b      = ex_b;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op[0])           state_n = S_MUL;
                    else if (srcB == '0)  state_n = S_DONE;
                    else                  state_n = S_DIV_CMP;
                end
            end
            S_MUL: begin
                alu_signal = ALU_ADD;
                alu_a      = acc_hi;
                alu_b      = acc_lo[0] ? operand : '0;
                if (last_iter) state_n = S_DONE;
            end
            S_DIV_CMP: begin
                alu_signal = ALU_SLT;
                alu_a      = div_s;
                alu_b      = operand;
                state_n    = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                alu_signal = ALU_SUB;
                alu_a      = s_reg;
                alu_b      = operand;
                state_n    = last_iter ? S_DONE : S_DIV_CMP;
            end
            S_DONE: begin
                alu_signal = ALU_ADD;
                alu_a      = '0;
                alu_b      = '0;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            s_reg    <= '0;
            ov_reg   <= 1'b0;
            lt_reg   <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        if (!op[0]) begin
                            acc_hi  <= '0;
                            acc_lo  <= srcB;
                            operand <= srcA;
                        end else if (srcB != '0) begin
                            acc_hi  <= '0;
                            acc_lo  <= srcA;
                            operand <= srcB;
                        end else begin
                            hi       <= srcA;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + 5'd1;
                    if (last_iter) begin
                        hi <= mul_hi_n;
                        lo <= mul_lo_n;
                    end
                end
                S_DIV_CMP: begin
                    s_reg  <= div_s;
                    ov_reg <= acc_hi[31];
                    lt_reg <= alu_result[0];
                    acc_lo <= acc_lo << 1;
                end
                S_DIV_SUB: begin
                    acc_hi <= rem_n;
                    acc_lo <= quo_n;
                    cnt    <= cnt + 5'd1;
                    if (last_iter) begin
                        hi <= rem_n;
                        lo <= quo_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed self-checking bench for alu_muldiv_seq, with a
// behavioural model of the shared ALU closing the alu_* loop.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic [2:0]  ex_signal;
    logic [31:0] ex_a, ex_b;
    logic [2:0]  alu_signal;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .srcA       (src_a),
        .srcB       (src_b),
        .ex_signal  (ex_signal),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .alu_signal (alu_signal),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    // Shared ALU model: SLT is an unsigned compare.
    always_comb begin
        case (alu_signal)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = {31'd0, (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
    end

    // Issue one op at a negedge (cycle 0) and wait for done; returns the cycle
    // done was seen in (-1 on timeout) and whether busy was high throughout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        ex_signal = '0; ex_a = '0; ex_b = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy/done/dz=%b hi=%h lo=%h, need 000 0 0",
                     {busy, done, div_zero}, hi, lo);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        ex_signal = 3'b010; ex_a = 32'd5; ex_b = 32'd7;
        #1;
        total++;
        if (alu_signal !== 3'b010 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            bad++;
            $display("FAIL passthrough: got %b/%0d/%0d need 010/5/7", alu_signal, alu_a, alu_b);
        end
        ex_signal = 3'b000; ex_a = 32'hA5A5_0000; ex_b = 32'h0000_5A5A;
        #1;
        total++;
        if (alu_signal !== 3'b000 || alu_a !== 32'hA5A5_0000 || alu_b !== 32'h0000_5A5A) begin
            bad++;
            $display("FAIL passthrough2: got %b/%h/%h need 000/a5a50000/00005a5a",
                     alu_signal, alu_a, alu_b);
        end
        ex_signal = 3'b010; ex_a = 32'd5; ex_b = 32'd7;
    endtask

    task automatic test_mul_max();
        int lat; bit bok;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
        total++;
        if (lat != 33) begin
            bad++; $display("FAIL mul_latency: done cycle %0d need 33", lat);
        end
        total++;
        if (!bok) begin
            bad++; $display("FAIL mul_busy: busy dropped in cycles 1..33, need high");
        end
        total++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            bad++; $display("FAIL mul_max: hi=%h lo=%h need fffffffe/00000001", hi, lo);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            bad++; $display("FAIL mul_after: busy=%b done=%b hi=%h lo=%h need 0 0 held",
                            busy, done, hi, lo);
        end
    endtask

    task automatic test_mul_misc();
        int lat; bit bok;
        run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, lat, bok);
        total++;
        if (lat != 33 || hi !== 32'h0000_0001 || lo !== 32'h2345_6780) begin
            bad++; $display("FAIL mul_shift: lat=%0d hi=%h lo=%h need 33 00000001/23456780",
                            lat, hi, lo);
        end
    endtask

    task automatic test_div();
        int lat; bit bok;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bok);
        total++;
        if (lat != 65 || !bok) begin
            bad++; $display("FAIL div_latency: done cycle %0d busy_ok=%0d need 65/1", lat, bok);
        end
        total++;
        if (lo !== 32'd14 || hi !== 32'd2 || div_zero !== 1'b0) begin
            bad++; $display("FAIL div_100_7: lo=%0d hi=%0d dz=%b need 14 2 0", lo, hi, div_zero);
        end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, lat, bok);
        total++;
        if (lat != 65 || lo !== 32'd1 || hi !== 32'h7FFF_FFFE) begin
            bad++; $display("FAIL div_ov: lat=%0d lo=%h hi=%h need 65 1 7ffffffe", lat, lo, hi);
        end
        run_op(OP_DIVU, 32'h10, 32'h20, lat, bok);
        total++;
        if (lo !== 32'd0 || hi !== 32'h10) begin
            bad++; $display("FAIL div_small: lo=%h hi=%h need 0 10", lo, hi);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok;
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat, bok);
        total++;
        if (lat != 1 || !bok) begin
            bad++; $display("FAIL dz_latency: done cycle %0d busy_ok=%0d need 1/1", lat, bok);
        end
        total++;
        if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
            bad++; $display("FAIL dz_result: hi=%h lo=%h dz=%b need 12345678 ffffffff 1",
                            hi, lo, div_zero);
        end
        @(negedge clk);
        total++;
        if (div_zero !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL dz_hold: dz=%b busy=%b need 1 0", div_zero, busy);
        end
        run_op(OP_MULTU, 32'd3, 32'd5, lat, bok);
        total++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd15 || div_zero !== 1'b0) begin
            bad++; $display("FAIL dz_clear: lat=%0d hi=%h lo=%h dz=%b need 33 0 15 0",
                            lat, hi, lo, div_zero);
        end
    endtask

    task automatic test_ignore();
        int lat;
        logic [31:0] hi0, lo0;
        // Illegal op in IDLE: nothing changes.
        hi0 = hi; lo0 = lo;
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== hi0 || lo !== lo0) begin
            bad++; $display("FAIL illegal_op: busy=%b done=%b hi=%h lo=%h need idle/unchanged",
                            busy, done, hi, lo);
        end
        // MULTU 3x5 with a DIVU-by-zero start poked at cycle 5.
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (alu_signal !== 3'b010 || alu_a !== 32'd0 || alu_b !== 32'd3) begin
            bad++; $display("FAIL alu_owned: got %b/%0d/%0d need 010/0/3 (not ex_*)",
                            alu_signal, alu_a, alu_b);
        end
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 5) begin
                start = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd15 || div_zero !== 1'b0) begin
            bad++; $display("FAIL busy_start: lat=%0d hi=%h lo=%h dz=%b need 33 0 15 0",
                            lat, hi, lo, div_zero);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok;
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd1000; src_b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;  // cycle 10
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (saw_done || busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_mid: early_done=%0d busy=%b done=%b hi=%h lo=%h need 0 0 0 0 0",
                            saw_done, busy, done, hi, lo);
        end
        run_op(OP_MULTU, 32'd1000, 32'd1000, lat, bok);
        total++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd1000000) begin
            bad++; $display("FAIL after_reset: lat=%0d hi=%h lo=%0d need 33 0 1000000", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        // run_op returns at the DONE cycle, so the next start lands in the cycle after.
        run_op(OP_DIVU, 32'd1000, 32'd10, lat, bok);
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, bok);
        total++;
        if (lat != 33 || hi !== 32'd1 || lo !== 32'd0) begin
            bad++; $display("FAIL back_to_back: lat=%0d hi=%h lo=%h need 33 1 0", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_mul_max();
        test_mul_misc();
        test_div();
        test_div_zero();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
